// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master sequencer: generates START/STOP line sequences itself and
// splits WRITE/READ into nine bit requests (8 data MSB first + ACK) for i2c_bit_gen.
module i2c_byte_ctrl #(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned I2C_FREQ = 100_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd,
    input  logic [7:0] i_wr_byte,
    input  logic       i_rd_nack,
    output logic       o_done,
    output logic       o_err,
    output logic [7:0] o_rd_byte,
    output logic       o_ack,
    output logic       o_bus_active,
    output logic       o_bit_req,
    output logic       o_bit_we,
    output logic       o_bit_wr,
    input  logic       i_bit_ready,
    input  logic       i_bit_rd_valid,
    input  logic       i_bit_rd,
    output logic       o_own,
    output logic       o_sda,
    output logic       o_scl
);

    localparam int unsigned Q  = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned QW = (Q > 1) ? $clog2(Q + 1) : 1;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_STOP  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_BUSY  = 3'd4;
    localparam logic [2:0] ST_WAIT  = 3'd5;

    localparam logic [3:0] LAST_BIT = 4'd8;

    logic [2:0]    state, nxt_state;
    logic [1:0]    phase, nxt_phase;
    logic [QW-1:0] phase_cnt, nxt_phase_cnt;
    logic [3:0]    bit_cnt, nxt_bit_cnt;
    logic          is_read, nxt_is_read;
    logic [7:0]    wr_byte, nxt_wr_byte;
    logic          rd_nack, nxt_rd_nack;
    logic          nxt_cmd_ready, nxt_done, nxt_err, nxt_ack, nxt_bus_active;
    logic          nxt_bit_req, nxt_bit_we, nxt_bit_wr, nxt_own, nxt_sda, nxt_scl;
    logic [7:0]    nxt_rd_byte;
    logic          phase_end;

    // {we, wr} for bit n of a transfer
    function automatic logic [1:0] bit_fields(input logic rd, input logic [3:0] n,
                                              input logic [7:0] b, input logic nack);
        logic [1:0] f;
        if (n == LAST_BIT)
            f = rd ? {1'b1, nack} : 2'b00;
        else
            f = rd ? 2'b00 : {1'b1, b[3'(4'd7 - n)]};
        return f;
    endfunction

    // {sda, scl} for START phases P0..P3
    function automatic logic [1:0] start_lines(input logic [1:0] p);
        logic [1:0] l;
        case (p)
            2'd0:    l = 2'b10;
            2'd1:    l = 2'b11;
            2'd2:    l = 2'b01;
            default: l = 2'b00;
        endcase
        return l;
    endfunction

    // {sda, scl} for STOP phases P0..P2
    function automatic logic [1:0] stop_lines(input logic [1:0] p);
        logic [1:0] l;
        case (p)
            2'd0:    l = 2'b00;
            2'd1:    l = 2'b01;
            default: l = 2'b11;
        endcase
        return l;
    endfunction

    assign phase_end = (phase_cnt == QW'(Q));

    // next-state and next-output logic
    always_comb begin
        nxt_state      = state;
        nxt_phase      = phase;
        nxt_phase_cnt  = phase_cnt;
        nxt_bit_cnt    = bit_cnt;
        nxt_is_read    = is_read;
        nxt_wr_byte    = wr_byte;
        nxt_rd_nack    = rd_nack;
        nxt_done       = 1'b0;
        nxt_err        = 1'b0;
        nxt_ack        = o_ack;
        nxt_rd_byte    = o_rd_byte;
        nxt_bus_active = o_bus_active;
        nxt_bit_req    = o_bit_req;
        nxt_bit_we     = o_bit_we;
        nxt_bit_wr     = o_bit_wr;
        nxt_sda        = o_sda;
        nxt_scl        = o_scl;

        case (state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    nxt_phase_cnt = '0;
                    case (i_cmd)
                        CMD_START: begin
                            nxt_state = ST_START;
                            // lines already high when idle, so P0 is only needed for repeated start
                            nxt_phase = o_bus_active ? 2'd0 : 2'd1;
                            {nxt_sda, nxt_scl} = start_lines(o_bus_active ? 2'd0 : 2'd1);
                        end
                        CMD_STOP: begin
                            if (o_bus_active) begin
                                nxt_state = ST_STOP;
                                nxt_phase = 2'd0;
                                {nxt_sda, nxt_scl} = stop_lines(2'd0);
                            end else begin
                                nxt_done = 1'b1;
                            end
                        end
                        default: begin
                            if (o_bus_active) begin
                                nxt_state   = ST_ISSUE;
                                nxt_is_read = i_cmd[0];
                                nxt_wr_byte = i_wr_byte;
                                nxt_rd_nack = i_rd_nack;
                                nxt_bit_cnt = '0;
                                nxt_bit_req = 1'b1;
                                {nxt_bit_we, nxt_bit_wr} = bit_fields(i_cmd[0], 4'd0, i_wr_byte, i_rd_nack);
                            end else begin
                                nxt_done = 1'b1;
                                nxt_err  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_START: begin
                if (phase_end) begin
                    nxt_phase_cnt = '0;
                    if (phase == 2'd3) begin
                        nxt_state      = ST_IDLE;
                        nxt_done       = 1'b1;
                        nxt_bus_active = 1'b1;
                    end else begin
                        nxt_phase = phase + 2'd1;
                        {nxt_sda, nxt_scl} = start_lines(phase + 2'd1);
                    end
                end else begin
                    nxt_phase_cnt = phase_cnt + QW'(1);
                end
            end
            ST_STOP: begin
                if (phase_end) begin
                    nxt_phase_cnt = '0;
                    if (phase == 2'd2) begin
                        nxt_state      = ST_IDLE;
                        nxt_done       = 1'b1;
                        nxt_bus_active = 1'b0;
                        nxt_sda        = 1'b1;
                        nxt_scl        = 1'b1;
                    end else begin
                        nxt_phase = phase + 2'd1;
                        {nxt_sda, nxt_scl} = stop_lines(phase + 2'd1);
                    end
                end else begin
                    nxt_phase_cnt = phase_cnt + QW'(1);
                end
            end
            ST_ISSUE: begin
                if (o_bit_req && i_bit_ready) begin
                    nxt_bit_req = 1'b0;
                    nxt_state   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!i_bit_ready)
                    nxt_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_bit_ready) begin
                    if (bit_cnt == LAST_BIT) begin
                        nxt_state  = ST_IDLE;
                        nxt_done   = 1'b1;
                        nxt_bit_we = 1'b0;
                        nxt_bit_wr = 1'b0;
                    end else begin
                        nxt_bit_cnt = bit_cnt + 4'd1;
                        nxt_state   = ST_ISSUE;
                        nxt_bit_req = 1'b1;
                        {nxt_bit_we, nxt_bit_wr} = bit_fields(is_read, bit_cnt + 4'd1, wr_byte, rd_nack);
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase

        // read data only counts while a we=0 bit is in flight
        if ((state == ST_BUSY || state == ST_WAIT) && i_bit_rd_valid && !o_bit_we) begin
            if (is_read)
                nxt_rd_byte = {o_rd_byte[6:0], i_bit_rd};
            else
                nxt_ack = i_bit_rd;
        end

        nxt_own = (nxt_state == ST_START) || (nxt_state == ST_STOP) ||
                  (nxt_state == ST_IDLE && !nxt_bus_active);
        nxt_cmd_ready = (nxt_state == ST_IDLE);
    end

    // state and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            phase        <= 2'd0;
            phase_cnt    <= '0;
            bit_cnt      <= '0;
            is_read      <= 1'b0;
            wr_byte      <= '0;
            rd_nack      <= 1'b0;
            o_cmd_ready  <= 1'b1;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_rd_byte    <= '0;
            o_ack        <= 1'b1;
            o_bus_active <= 1'b0;
            o_bit_req    <= 1'b0;
            o_bit_we     <= 1'b0;
            o_bit_wr     <= 1'b0;
            o_own        <= 1'b1;
            o_sda        <= 1'b1;
            o_scl        <= 1'b1;
        end else begin
            state        <= nxt_state;
            phase        <= nxt_phase;
            phase_cnt    <= nxt_phase_cnt;
            bit_cnt      <= nxt_bit_cnt;
            is_read      <= nxt_is_read;
            wr_byte      <= nxt_wr_byte;
            rd_nack      <= nxt_rd_nack;
            o_cmd_ready  <= nxt_cmd_ready;
            o_done       <= nxt_done;
            o_err        <= nxt_err;
            o_rd_byte    <= nxt_rd_byte;
            o_ack        <= nxt_ack;
            o_bus_active <= nxt_bus_active;
            o_bit_req    <= nxt_bit_req;
            o_bit_we     <= nxt_bit_we;
            o_bit_wr     <= nxt_bit_wr;
            o_own        <= nxt_own;
            o_sda        <= nxt_sda;
            o_scl        <= nxt_scl;
        end
    end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Randomized bench for i2c_byte_ctrl with a behavioural bit-generator/slave model
// and a byte-level reference of the expected bit requests and line sequences.
module tb_i2c_byte_ctrl;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_READ  = 2'd3;
    localparam int PH = 63;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [7:0] wr_byte = 8'd0;
    logic rd_nack = 1'b0;
    logic bit_ready = 1'b0;
    logic bit_rd_valid = 1'b0;
    logic bit_rd = 1'b0;

    logic cmd_ready, done, err, ack, bus_active, bit_req, bit_we, bit_wr, own, sda, scl;
    logic [7:0] rd_byte;

    int total = 0;
    int bad = 0;

    logic [1:0] req_log[$];
    int base = 0;
    logic [7:0] slave_byte = 8'd0;
    logic slave_ack = 1'b0;
    logic [7:0] exp_rd = 8'd0;
    logic exp_ack = 1'b1;

    int m_st = 0;
    int m_busy = 0;
    logic m_we = 1'b0;

    i2c_byte_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd(cmd),
        .i_wr_byte(wr_byte), .i_rd_nack(rd_nack),
        .o_done(done), .o_err(err), .o_rd_byte(rd_byte), .o_ack(ack),
        .o_bus_active(bus_active),
        .o_bit_req(bit_req), .o_bit_we(bit_we), .o_bit_wr(bit_wr),
        .i_bit_ready(bit_ready), .i_bit_rd_valid(bit_rd_valid), .i_bit_rd(bit_rd),
        .o_own(own), .o_sda(sda), .o_scl(scl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bit generator + slave: accepts req&ready, stays busy a random time, returns slave data on we=0 bits
    always @(negedge clk) begin
        if (rst) begin
            m_st = 0;
            bit_ready = 1'b0;
            bit_rd_valid = 1'b0;
        end else begin
            bit_rd_valid = 1'b0;
            case (m_st)
                0: begin
                    if (!bit_ready) begin
                        bit_ready = 1'b1;
                    end else if (bit_req) begin
                        req_log.push_back({bit_we, bit_wr});
                        m_we = bit_we;
                        m_st = 1;
                    end else if ($urandom_range(0, 5) == 0) begin
                        bit_rd_valid = 1'b1;
                        bit_rd = 1'($urandom);
                    end
                end
                1: begin
                    bit_ready = 1'b0;
                    m_busy = $urandom_range(1, 6);
                    m_st = 2;
                end
                default: begin
                    if (m_busy > 1) begin
                        m_busy--;
                    end else begin
                        int k;
                        k = req_log.size() - 1 - base;
                        bit_ready = 1'b1;
                        if (!m_we) begin
                            bit_rd_valid = 1'b1;
                            bit_rd = (k < 8) ? slave_byte[7 - k] : slave_ack;
                        end
                        m_st = 0;
                    end
                end
            endcase
        end
    end

    function automatic logic [17:0] exp_seq(input logic rd, input logic [7:0] b, input logic nack);
        logic [17:0] s;
        s = '0;
        for (int k = 0; k < 8; k++)
            s = {s[15:0], (rd ? 2'b00 : {1'b1, b[7 - k]})};
        s = {s[15:0], (rd ? {1'b1, nack} : 2'b00)};
        return s;
    endfunction

    function automatic logic [17:0] obs_seq();
        logic [17:0] s;
        logic [1:0] e;
        s = '0;
        for (int i = base; i < base + 9 && i < req_log.size(); i++) begin
            e = req_log[i];
            if (!e[1]) e[0] = 1'b0;
            s = {s[15:0], e};
        end
        return s;
    endfunction

    task automatic run_cmd(input logic [1:0] c, input logic [7:0] b, input logic nack,
                           output int cyc, output logic [15:0] trace, output int tn,
                           output logic own_all, output logic req_seen);
        int last;
        check("cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd = c;
        wr_byte = b;
        rd_nack = nack;
        base = req_log.size();
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0; trace = '0; tn = 0; own_all = 1'b1; req_seen = 1'b0; last = -1;
        while (!done && cyc < 3000) begin
            own_all &= own;
            if (bit_req) req_seen = 1'b1;
            if (own && int'({sda, scl}) != last) begin
                trace = {trace[13:0], sda, scl};
                last = int'({sda, scl});
                tn++;
            end
            @(negedge clk);
            cyc++;
        end
        check("done", 32'(done), 1);
    endtask

    task automatic do_inactive(input logic [1:0] c, input logic exp_err);
        int cyc, tn; logic [15:0] tr; logic oa, rs;
        run_cmd(c, 8'h00, 1'b0, cyc, tr, tn, oa, rs);
        check("inact_cyc", 32'(cyc), 0);
        check("inact_err", 32'(err), 32'(exp_err));
        check("inact_noreq", 32'(rs), 0);
        check("inact_bus", 32'(bus_active), 0);
    endtask

    task automatic do_start(input logic active);
        int cyc, tn; logic [15:0] tr; logic oa, rs;
        run_cmd(CMD_START, 8'h00, 1'b0, cyc, tr, tn, oa, rs);
        check("start_cyc", 32'(cyc), active ? 4 * PH : 3 * PH);
        check("start_trace", 32'(tr), active ? 32'hB4 : 32'h34);
        check("start_tn", 32'(tn), active ? 4 : 3);
        check("start_own", 32'(oa), 1);
        check("start_bus", 32'(bus_active), 1);
        check("start_err", 32'(err), 0);
        check("start_own_after", 32'(own), 0);
    endtask

    task automatic do_stop();
        int cyc, tn; logic [15:0] tr; logic oa, rs;
        run_cmd(CMD_STOP, 8'h00, 1'b0, cyc, tr, tn, oa, rs);
        check("stop_cyc", 32'(cyc), 3 * PH);
        check("stop_trace", 32'(tr), 32'h07);
        check("stop_tn", 32'(tn), 3);
        check("stop_bus", 32'(bus_active), 0);
        check("stop_own", 32'(own), 1);
        check("stop_lines", 32'({sda, scl}), 3);
        check("stop_err", 32'(err), 0);
    endtask

    task automatic do_write(input logic [7:0] b, input logic a);
        int cyc, tn; logic [15:0] tr; logic oa, rs;
        slave_ack = a;
        run_cmd(CMD_WRITE, b, 1'($urandom), cyc, tr, tn, oa, rs);
        check("wr_nreq", 32'(req_log.size() - base), 9);
        check("wr_seq", 32'(obs_seq()), 32'(exp_seq(1'b0, b, 1'b0)));
        check("wr_ack", 32'(ack), 32'(a));
        check("wr_err", 32'(err), 0);
        check("wr_rd_hold", 32'(rd_byte), 32'(exp_rd));
        exp_ack = a;
    endtask

    task automatic do_read(input logic [7:0] b, input logic nack);
        int cyc, tn; logic [15:0] tr; logic oa, rs;
        slave_byte = b;
        run_cmd(CMD_READ, 8'($urandom), nack, cyc, tr, tn, oa, rs);
        check("rd_nreq", 32'(req_log.size() - base), 9);
        check("rd_seq", 32'(obs_seq()), 32'(exp_seq(1'b1, 8'h00, nack)));
        check("rd_byte", 32'(rd_byte), 32'(b));
        check("rd_err", 32'(err), 0);
        check("rd_ack_hold", 32'(ack), 32'(exp_ack));
        exp_rd = b;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_own"}, 32'(own), 1);
        check({tag, "_sda"}, 32'(sda), 1);
        check({tag, "_scl"}, 32'(scl), 1);
        check({tag, "_ready"}, 32'(cmd_ready), 1);
        check({tag, "_bus"}, 32'(bus_active), 0);
        check({tag, "_req"}, 32'({bit_req, bit_we, bit_wr}), 0);
        check({tag, "_done"}, 32'({done, err}), 0);
        check({tag, "_rd"}, 32'(rd_byte), 0);
        check({tag, "_ack"}, 32'(ack), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_inactive(CMD_WRITE, 1'b1);
        do_inactive(CMD_READ, 1'b1);
        do_inactive(CMD_STOP, 1'b0);

        do_start(1'b0);
        do_write(8'hA5, 1'b0);
        do_read(8'h3C, 1'b1);

        for (int i = 0; i < 12; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)
                do_write(8'($urandom), 1'($urandom));
            else if (r < 8)
                do_read(8'($urandom), 1'($urandom));
            else
                do_start(1'b1);
        end

        do_write(8'h00, 1'b1);
        do_read(8'hFF, 1'b0);
        do_start(1'b1);
        do_stop();
        do_inactive(CMD_READ, 1'b1);

        // asynchronous reset in the middle of a WRITE
        do_start(1'b0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd = CMD_WRITE;
        wr_byte = 8'h5A;
        base = req_log.size();
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_busy", 32'(cmd_ready), 0);
        #2 rst = 1'b1;
        #1 check_reset_vals("async");
        @(negedge clk);
        rst = 1'b0;
        exp_rd = 8'h00;
        exp_ack = 1'b1;
        repeat (2) @(negedge clk);
        do_inactive(CMD_WRITE, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
